counter_02: RTL
===============

Name: counter_02

Overview:
- Parametrised successor to the team's free-running up-counter.
- Adds up/down direction, synchronous parallel load, programmable modulo (top value), and a wrap-or-saturate mode.
- Adds a registered terminal-count pulse and a sticky wrap flag.
- Used as the general-purpose event/timebase counter in test benches and small datapaths; drives timers and address generators.

Parameters:
- bus_width, 8, width of count, load value and top value.
- rst_val, 0, value loaded into out on reset; must be <= (2^bus_width)-1.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  synchronous active-low reset; sampled on posedge clk.
- ebl  input  1  count enable; one step per posedge while high.
- dir  input  1  1 = count up, 0 = count down.
- sat  input  1  0 = wrap at limits, 1 = saturate (hold) at limits.
- ld  input  1  synchronous load request.
- ld_val  input  bus_width  value to load.
- top  input  bus_width  modulo limit; count range is 0..top inclusive.
- out  output  bus_width  current count (registered).
- tc  output  1  terminal-count pulse (registered).
- wrapped  output  1  sticky flag, set on any wrap.

Behaviour:
- Reset: rst==0 at posedge -> out=rst_val, tc=0, wrapped=0. This overrides ld/ebl and applies mid-count.
- Priority per posedge: rst > ld > ebl. With none active, out holds and tc=0.
- Load: ld==1 -> out=min(ld_val, top), tc=0, wrapped cleared. ebl is ignored that cycle.
- Latency: out reflects a step or load on the posedge that samples the request (1-cycle register latency). There is no combinational path from inputs to outputs.
- Up step (ebl=1, dir=1):
  - out<top -> out+1.
  - out==top, sat=0 -> out=0, tc=1, wrapped=1.
  - out==top, sat=1 -> out holds at top, tc=1, wrapped unchanged.
- Down step (ebl=1, dir=0):
  - out>0 -> out-1.
  - out==0, sat=0 -> out=top, tc=1, wrapped=1.
  - out==0, sat=1 -> out holds at 0, tc=1.
- tc is a one-cycle pulse per terminal event. If ebl stays high at a saturated limit, tc stays high every such cycle.
- Out of range: top lowered below the current out (out>top) with ebl=1 -> next out=0 for up, top for down. tc=0, no wrap flag.
- top==0: out pinned at 0. Each enabled step is a terminal event (tc=1; wrapped=1 if sat=0).
- top==all-ones: full natural modulo 2^bus_width. No arithmetic overflow beyond bus_width; compute internally with bus_width bits plus compare, never a bus_width+1 sum.
- dir, sat and top may change on any cycle; they take effect at the next posedge.
- All outputs are X-free after the first reset posedge.

Decomposition:
- Shared package counter_pkg holds:
  - DIR_DOWN=0, DIR_UP=1.
  - MODE_WRAP=0, MODE_SAT=1.
  - Default bus width constant CNT_W_DEF=8.
- One natural sub-module: counter_02_next, purely combinational. Inputs: out, dir, sat, top. Outputs: nxt, term, wrap_ev.
- The top-level counter_02 holds only the registers and the priority mux.

Test Plan:
1. bus_width=4, top=9, dir=1, sat=0: reset, then ebl=1 for 12 cycles -> out 0..9,0,1; tc=1 exactly on the cycle out goes 9->0; wrapped=1 from then on.
2. bus_width=4, top=5, dir=0, sat=1: ld=1 with ld_val=2, then ebl=1 for 4 cycles -> out 2,1,0,0,0; tc=1 on both hold cycles at 0; wrapped=0.
3. bus_width=4, top=15: ld_val=12, ld and ebl both 1 on the same posedge -> out=12, tc=0. Then ld_val=20 is not expressible at this width, so with top=7 and ld_val=12 -> out=7 (clamped).
4. Counting up at out=6, top=9: drop rst to 0 for one posedge with ebl=1, ld=1 -> out=rst_val (0), tc=0, wrapped=0. Counting resumes 1,2 once rst returns high.
5. out=8, top changes 9->3 with ebl=1, dir=1 -> next out=0, tc=0, wrapped unchanged. With dir=0 instead -> next out=3.
6. top=0, sat=0, ebl=1 for 3 cycles -> out stays 0, tc=1 on all 3 cycles, wrapped=1. ebl=0 -> tc=0, out=0.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared direction/mode encodings and default width for the counter_02 family.
package counter_pkg;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam int   CNT_W_DEF = 8;
endpackage

// File: rtl/counter_02_next.sv
// counter_02_next: combinational next-count, terminal-event and wrap-event logic.
module counter_02_next
    import counter_pkg::*;
#(
    parameter int bus_width = CNT_W_DEF
) (
    input  logic [bus_width-1:0] out,
    input  logic                 dir,
    input  logic                 sat,
    input  logic [bus_width-1:0] top,
    output logic [bus_width-1:0] nxt,
    output logic                 term,
    output logic                 wrap_ev
);
    logic w_up, w_oor, w_lim;
    assign w_up    = (dir == DIR_UP);
    // A count left above a lowered top snaps back into range without a terminal event.
    assign w_oor   = (out > top);
    assign w_lim   = w_up ? (out == top) : (out == '0);
    assign term    = !w_oor && w_lim;
    assign wrap_ev = term && (sat == MODE_WRAP);
    assign nxt     = w_oor ? (w_up ? '0 : top)
                   : w_lim ? ((sat == MODE_SAT) ? out : (w_up ? '0 : top))
                   : w_up  ? out + 1'b1 : out - 1'b1;
endmodule

// File: rtl/counter_02.sv
// counter_02: up/down modulo counter with load, wrap/saturate, terminal-count pulse and sticky wrap flag.
module counter_02
    import counter_pkg::*;
#(
    parameter int                   bus_width = CNT_W_DEF,
    parameter logic [bus_width-1:0] rst_val   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ebl,
    input  logic                 dir,
    input  logic                 sat,
    input  logic                 ld,
    input  logic [bus_width-1:0] ld_val,
    input  logic [bus_width-1:0] top,
    output logic [bus_width-1:0] out,
    output logic                 tc,
    output logic                 wrapped
);
    logic [bus_width-1:0] r_out, w_nxt, w_ld;
    logic                 r_tc, r_wrapped, w_term, w_wrap_ev;

    counter_02_next #(.bus_width(bus_width)) u_next (
        .out(r_out), .dir(dir), .sat(sat), .top(top),
        .nxt(w_nxt), .term(w_term), .wrap_ev(w_wrap_ev)
    );

    assign w_ld = (ld_val > top) ? top : ld_val;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out     <= rst_val;
            r_tc      <= 1'b0;
            r_wrapped <= 1'b0;
        end else if (ld) begin
            r_out     <= w_ld;
            r_tc      <= 1'b0;
            r_wrapped <= 1'b0;
        end else if (ebl) begin
            r_out     <= w_nxt;
            r_tc      <= w_term;
            r_wrapped <= r_wrapped | w_wrap_ev;
        end else begin
            r_tc      <= 1'b0;
        end
    end

    assign out     = r_out;
    assign tc      = r_tc;
    assign wrapped = r_wrapped;
endmodule
